// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result stage: condition check, NZCV commit, writeback FIFO
//
// Purpose:
//   Takes one ALU result per cycle, evaluates its ARM condition code against
//   the committed NZCV flags, commits new flags when the instruction passes and
//   sets S, and queues passing register writebacks in a small FIFO so that
//   register-file stalls do not stall the ALU directly.
//
// Ports:
//   CLK, RESET_N             clock (rising edge), asynchronous active-low reset
//   IN_VALID / IN_READY      upstream handshake; IN_READY depends only on FIFO fill
//   ALU_OUT, NZCV            ALU result and ALU flags ([3]=N [2]=Z [1]=C [0]=V)
//   COND, S_BIT, WE, RD      condition field, flag-update, write-enable, destination
//   WB_VALID / WB_READY      writeback handshake toward the register file
//   WB_DATA, WB_ADDR         FIFO head (last popped entry when the FIFO is empty)
//   FLAGS                    committed NZCV
//   SKIP_CNT                 saturating count of condition-failed instructions

module alu_result_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DEPTH     = 2,
  parameter logic [3:0]  FLAG_INIT = 4'b0000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [3:0]        NZCV,
  input  logic [3:0]        COND,
  input  logic              S_BIT,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RD,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [3:0]        FLAGS,
  output logic [15:0]       SKIP_CNT
);

  localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] last_data;
  logic [ADDR_W-1:0] last_addr;
  logic [3:0]        flags_q;
  logic [15:0]       skip_q;

  logic accept;
  logic pass;
  logic push;
  logic pop;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Ready looks only at the registered fill level, so a same-cycle pop on a
  // full FIFO does not open a slot until the next cycle.
  assign IN_READY = RESET_N && (count < FULL_CNT);
  assign accept   = IN_VALID && IN_READY;
  // Condition uses committed flags, never the incoming NZCV.
  assign pass     = cond_pass(COND, flags_q);
  assign push     = accept && pass && WE;
  assign pop      = WB_VALID && WB_READY;

  assign WB_VALID = (count != '0);
  assign WB_DATA  = WB_VALID ? data_mem[rd_ptr] : last_data;
  assign WB_ADDR  = WB_VALID ? addr_mem[rd_ptr] : last_addr;
  assign FLAGS    = flags_q;
  assign SKIP_CNT = skip_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
      last_addr <= '0;
      flags_q   <= FLAG_INIT;
      skip_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_data <= data_mem[rd_ptr];
        last_addr <= addr_mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
      if (accept && pass && S_BIT) begin
        flags_q <= NZCV;
      end
      if (accept && !pass && (skip_q != 16'hFFFF)) begin
        skip_q <= skip_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only observable while count covers them.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= ALU_OUT;
      addr_mem[wr_ptr] <= RD;
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Sits directly downstream of the combinational ALU in the execute path. Each cycle it can accept one instruction's ALU_OUT and NZCV.
- Evaluates the instruction's ARM condition code against the committed flags, then updates the flag register (CPSR NZCV) and queues register writebacks.
- A DEPTH-entry writeback FIFO decouples the ALU from register-file write stalls.

Parameters:
DATA_W, 32, width of ALU result and writeback data
ADDR_W, 4, destination register index width
DEPTH, 2, writeback FIFO entries (power of two, >=2)
FLAG_INIT, 4'b0000, reset value of committed flags

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
IN_VALID  in  1  upstream holds a valid instruction result
IN_READY  out  1  stage can accept this cycle
ALU_OUT  in  DATA_W  ALU result
NZCV  in  4  ALU flags, [3]=N [2]=Z [1]=C [0]=V
COND  in  4  ARM condition field
S_BIT  in  1  instruction updates flags
WE  in  1  instruction writes a register
RD  in  ADDR_W  destination register
WB_VALID  out  1  FIFO head valid
WB_READY  in  1  register file accepts head
WB_DATA  out  DATA_W  head data
WB_ADDR  out  ADDR_W  head destination
FLAGS  out  4  committed NZCV
SKIP_CNT  out  16  count of condition-failed instructions

Behaviour:
- Reset (async, RESET_N=0): FLAGS=FLAG_INIT, FIFO empty, WB_VALID=0, WB_DATA=0, WB_ADDR=0, SKIP_CNT=0, IN_READY=0 while RESET_N=0. Reset mid-operation discards all queued entries.
- IN_READY = RESET_N && (count < DEPTH). It depends on the registered count only, not on WB_READY, so there is no combinational path from WB_READY to IN_READY.
- Accept = IN_VALID && IN_READY. Everything below happens only on accept; otherwise state holds.
- PASS = f(COND, FLAGS) using the current registered FLAGS, not the incoming NZCV:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V
  - GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0 (never)
- Accept with PASS && S_BIT: FLAGS <= NZCV at that edge. The new flags are visible to the next accepted instruction's condition.
- Accept with PASS && WE: push {RD, ALU_OUT} into the FIFO.
- Accept with !PASS: no flag update, no push, SKIP_CNT += 1. SKIP_CNT saturates at 16'hFFFF.
- An instruction with PASS && !WE && !S_BIT is consumed silently.
- Dequeue: WB_VALID && WB_READY pops the head at the edge.
- WB_VALID = (count != 0). WB_DATA/WB_ADDR are the head entry; they show the last popped value (or 0 after reset) when empty.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push is only possible when count < DEPTH, so no overflow.
  - Pop on empty is ignored; WB_VALID=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Latency: an accepted entry appears at WB_VALID the cycle after accept. There is no combinational bypass from input to WB outputs.
- Ordering: writebacks leave strictly in acceptance order.

Test Plan:
- Reset then AL/S_BIT=1/WE=1, ALU_OUT=32'hEF000000, NZCV=4'b1010, RD=3 (0xFF000000+0xF0000000) -> next cycle FLAGS=1010, WB_VALID=1, WB_DATA=EF000000, WB_ADDR=3.
- FLAGS=1010, then EQ instr WE=1 -> skipped: no push, SKIP_CNT=1. Then CS instr WE=1 RD=5 ALU_OUT=1 -> pushed. Then HI instr -> passes (C=1, Z=0).
- WB_READY=0, three back-to-back AL WE=1 instrs (DEPTH=2) -> first two accepted, IN_READY=0 on the third. Raise WB_READY -> entries pop in order, third accepted one cycle later.
- Full FIFO, WB_READY=1 and IN_VALID=1 same cycle -> IN_READY=0 that cycle, so pop only. Next cycle accept; no loss or duplication.
- Flag chaining: instr A AL S_BIT=1 NZCV=0100, then instr B NE WE=1 immediately next cycle -> B is skipped (uses A's Z=1). Instr with COND=1111 is always skipped.
- Assert RESET_N=0 with 2 entries queued and FLAGS=1010 -> immediately WB_VALID=0, FLAGS=0000, SKIP_CNT=0. After release, the first accept behaves as after a cold reset.
